// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one single-port block RAM between two masters.
// Registered RAM command stage; read data returned through a tagged valid pipeline.
module ram_port_arbiter #(
    parameter int AW     = 5,
    parameter int DW     = 8,
    parameter int RD_LAT = 1
) (
    input  logic          clka,
    input  logic          rst,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_gnt,
    output logic          m0_rvalid,
    output logic [DW-1:0] m0_rdata,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_gnt,
    output logic          m1_rvalid,
    output logic [DW-1:0] m1_rdata,
    output logic          ram_ena,
    output logic          ram_wea,
    output logic [AW-1:0] ram_addra,
    output logic [DW-1:0] ram_dina,
    input  logic [DW-1:0] ram_douta
);

    // r_lp = id of the last master that transferred; the other one wins a tie.
    logic          r_lp;
    logic          r_ena;
    logic          r_wea;
    logic [AW-1:0] r_addra;
    logic [DW-1:0] r_dina;
    logic [RD_LAT:0] r_vld_pipe;
    logic [RD_LAT:0] r_id_pipe;

    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_xfer;
    logic          w_id;
    logic          w_we;
    logic [AW-1:0] w_addr;
    logic [DW-1:0] w_wdata;
    logic          w_rv0;
    logic          w_rv1;

    always_comb begin
        w_gnt0  = m0_req & (~m1_req | r_lp);
        w_gnt1  = m1_req & (~m0_req | ~r_lp);
        w_xfer  = w_gnt0 | w_gnt1;
        w_id    = w_gnt1;
        w_we    = w_gnt1 ? m1_we    : m0_we;
        w_addr  = w_gnt1 ? m1_addr  : m0_addr;
        w_wdata = w_gnt1 ? m1_wdata : m0_wdata;
    end

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            r_lp    <= 1'b1;
            r_ena   <= 1'b0;
            r_wea   <= 1'b0;
            r_addra <= '0;
            r_dina  <= '0;
        end else begin
            r_ena <= w_xfer;
            r_wea <= w_xfer & w_we;
            if (w_xfer) begin
                r_lp    <= w_id;
                r_addra <= w_addr;
                r_dina  <= w_wdata;
            end
        end
    end

    // Stage k holds the read issued k+1 edges ago; the last stage lines up with douta.
    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            r_vld_pipe <= '0;
            r_id_pipe  <= '0;
        end else begin
            r_vld_pipe[0] <= w_xfer & ~w_we;
            r_id_pipe[0]  <= w_id;
            for (int k = 1; k <= RD_LAT; k++) begin
                r_vld_pipe[k] <= r_vld_pipe[k-1];
                r_id_pipe[k]  <= r_id_pipe[k-1];
            end
        end
    end

    always_comb begin
        w_rv0 = r_vld_pipe[RD_LAT] & ~r_id_pipe[RD_LAT];
        w_rv1 = r_vld_pipe[RD_LAT] &  r_id_pipe[RD_LAT];
    end

    assign m0_gnt    = w_gnt0;
    assign m1_gnt    = w_gnt1;
    assign m0_rvalid = w_rv0;
    assign m1_rvalid = w_rv1;
    assign m0_rdata  = w_rv0 ? ram_douta : '0;
    assign m1_rdata  = w_rv1 ? ram_douta : '0;
    assign ram_ena   = r_ena;
    assign ram_wea   = r_wea;
    assign ram_addra = r_addra;
    assign ram_dina  = r_dina;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: three instances (RD_LAT 1..3) on shared stimulus, each
// with its own RAM model; the RD_LAT=1 instance is checked against a read scoreboard.
module tb_ram_port_arbiter;
    logic clka = 1'b0;
    logic rst  = 1'b0;
    always #5 clka = ~clka;

    logic       m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [4:0] m0_addr = 0, m1_addr = 0;
    logic [7:0] m0_wdata = 0, m1_wdata = 0;

    logic [3:1]      gnt0, gnt1, rv0, rv1, ena, wea;
    logic [3:1][4:0] addra;
    logic [3:1][7:0] dina, douta, rd0, rd1;

    for (genvar g = 1; g <= 3; g++) begin : g_lat
        logic [7:0] mem  [32];
        logic [7:0] pipe [g];
        always @(posedge clka) begin
            if (ena[g] && wea[g]) mem[addra[g]] <= dina[g];
            if (ena[g] && !wea[g]) pipe[0] <= mem[addra[g]];
            for (int k = 1; k < g; k++) pipe[k] <= pipe[k-1];
        end
        assign douta[g] = pipe[g-1];

        ram_port_arbiter #(.AW(5), .DW(8), .RD_LAT(g)) u_dut (
            .clka(clka), .rst(rst),
            .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
            .m0_gnt(gnt0[g]), .m0_rvalid(rv0[g]), .m0_rdata(rd0[g]),
            .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
            .m1_gnt(gnt1[g]), .m1_rvalid(rv1[g]), .m1_rdata(rd1[g]),
            .ram_ena(ena[g]), .ram_wea(wea[g]), .ram_addra(addra[g]), .ram_dina(dina[g]),
            .ram_douta(douta[g])
        );
    end

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clka) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    typedef struct {
        bit         id;
        logic [7:0] data;
        int         due;
    } exp_t;
    exp_t       q[$];
    logic [7:0] shadow [32];

    // Scoreboard on the RD_LAT=1 instance: check returns, then log the transfer due next edge.
    always @(negedge clka) begin
        exp_t e;
        if (!rst) begin
            q.delete();
        end else begin
            if (rv0[1] || rv1[1]) begin
                if (q.size() == 0) begin
                    chk("spurious_rvalid", {30'd0, rv1[1], rv0[1]}, 0);
                end else begin
                    e = q.pop_front();
                    chk("rv_cycle", cyc, e.due);
                    chk("rv_id", {30'd0, rv1[1], rv0[1]}, e.id ? 2 : 1);
                    chk("rv_data", e.id ? rd1[1] : rd0[1], e.data);
                    chk("rv_other_zero", e.id ? rd0[1] : rd1[1], 0);
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                chk("rv_missing", cyc, q[0].due);
                void'(q.pop_front());
            end
            if (m0_req && gnt0[1]) begin
                if (m0_we) shadow[m0_addr] = m0_wdata;
                else begin e.id = 0; e.data = shadow[m0_addr]; e.due = cyc + 2; q.push_back(e); end
            end
            if (m1_req && gnt1[1]) begin
                if (m1_we) shadow[m1_addr] = m1_wdata;
                else begin e.id = 1; e.data = shadow[m1_addr]; e.due = cyc + 2; q.push_back(e); end
            end
        end
    end

    task automatic step();
        @(posedge clka); #1;
    endtask

    task automatic idle();
        m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    endtask

    task automatic drive(input bit id, input bit we, input logic [4:0] a, input logic [7:0] d);
        if (id) begin m1_req = 1; m1_we = we; m1_addr = a; m1_wdata = d; end
        else    begin m0_req = 1; m0_we = we; m0_addr = a; m0_wdata = d; end
    endtask

    task automatic chk_gnt(input string tag, input bit g0, input bit g1);
        @(negedge clka);
        chk(tag, {30'd0, gnt1[1], gnt0[1]}, {30'd0, g1, g0});
    endtask

    task automatic drain();
        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clka);
        chk("drain", q.size(), 0);
    endtask

    task automatic pulse_reset();
        step(); rst = 0; step(); rst = 1;
    endtask

    initial begin
        int e;
        // Reset state
        repeat (2) @(posedge clka);
        @(negedge clka);
        chk("rst_ram", {ena[1], wea[1], addra[1], dina[1]}, 0);
        chk("rst_rv", {rv0, rv1}, 0);
        chk("rst_rdata", {rd0[1], rd1[1]}, 0);
        step(); rst = 1;

        // 1: m0 write then read addr 3
        drive(0, 1, 5'd3, 8'hA5);
        chk_gnt("t1_wr_gnt", 1, 0);
        step(); idle(); drive(0, 0, 5'd3, 8'h00);
        chk_gnt("t1_rd_gnt", 1, 0);
        chk("t1_ram_cmd", {ena[1], wea[1], addra[1], dina[1]}, {1'b1, 1'b1, 5'd3, 8'hA5});
        step(); idle();
        @(negedge clka);
        chk("t1_ram_rd", {ena[1], wea[1], addra[1]}, {1'b1, 1'b0, 5'd3});
        drain();

        // 2: contention, alternating grants starting with m0
        pulse_reset();
        drive(1, 1, 5'd4, 8'h5B);
        chk_gnt("t2_m1_wr", 0, 1);
        step(); idle();
        drive(0, 0, 5'd3, 8'h00); drive(1, 0, 5'd4, 8'h00);
        for (int i = 0; i < 6; i++) begin
            chk_gnt($sformatf("t2_gnt%0d", i), (i % 2) == 0, (i % 2) == 1);
            chk($sformatf("t2_ena%0d", i), ena[1], 1);
            step();
        end
        idle();
        @(negedge clka);
        chk("t2_ena_last", ena[1], 1);
        drain();

        // 3: top address and wrap to address 0
        drive(1, 1, 5'd31, 8'h3C);
        chk_gnt("t3_wr31", 0, 1);
        step(); idle(); drive(0, 0, 5'd31, 8'h00);
        chk_gnt("t3_rd31", 1, 0);
        step(); idle(); drive(1, 1, 5'd0, 8'h11);
        chk_gnt("t3_wr0", 0, 1);
        step(); idle(); drive(0, 0, 5'd0, 8'h00);
        chk_gnt("t3_rd0", 1, 0);
        step(); idle();
        drain();

        // 4: m1 alone, then the next tie goes to m0
        drive(1, 0, 5'd31, 8'h00);
        for (int i = 0; i < 4; i++) begin
            chk_gnt($sformatf("t4_m1_%0d", i), 0, 1);
            step();
        end
        drive(0, 0, 5'd0, 8'h00);
        chk_gnt("t4_tie", 1, 0);
        step(); idle();
        drain();

        // 5: reset one cycle after a read grant
        drive(0, 0, 5'd3, 8'h00);
        chk_gnt("t5_rd", 1, 0);
        step(); idle(); rst = 0; #1;
        chk("t5_ram_zero", {ena[1], wea[1], addra[1], dina[1]}, 0);
        chk("t5_out_zero", {rv0[1], rv1[1], rd0[1], rd1[1], gnt0[1], gnt1[1]}, 0);
        step(); rst = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clka);
            chk($sformatf("t5_no_rv%0d", i), {rv0, rv1}, 0);
        end
        step();
        drive(0, 0, 5'd3, 8'h00); drive(1, 0, 5'd4, 8'h00);
        chk_gnt("t5_tie", 1, 0);
        step(); idle();
        drain();

        // 6: deeper read latency instances
        drive(0, 1, 5'd7, 8'h5A);
        step(); idle(); drive(0, 0, 5'd7, 8'h00);
        @(negedge clka);
        e = cyc + 1;
        step(); idle();
        for (int k = 0; k < 5; k++) begin
            @(negedge clka);
            chk($sformatf("t6_l2_rv%0d", k), rv0[2], cyc == e + 2);
            chk($sformatf("t6_l3_rv%0d", k), rv0[3], cyc == e + 3);
            if (cyc == e + 2) chk("t6_l2_data", rd0[2], 8'h5A);
            if (cyc == e + 3) chk("t6_l3_data", rd0[3], 8'h5A);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
